// File: rtl/mul_shiftadd_acc.sv
// Sequential shift-add multiply-accumulator: product = multiplicand * multiplier + addend.
// One multiplier bit is consumed per clock. Start/done timing matches the subtract-shift divider.
module mul_shiftadd_acc #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     multiplicand,
    input  logic [DATA_W-1:0]     multiplier,
    input  logic [DATA_W-1:0]     addend,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);
    localparam int unsigned PC_W = $clog2(DATA_W + 5) + 1;
    localparam int unsigned P_W  = 2 * DATA_W + 1;

    localparam logic [PC_W-1:0] PC_IDLE    = PC_W'(0);
    localparam logic [PC_W-1:0] PC_LAST    = PC_W'(DATA_W);
    localparam logic [PC_W-1:0] PC_FINISH  = PC_W'(DATA_W + 1);

    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] a_reg;
    logic [P_W-1:0]    p;
    logic [DATA_W:0]   hi;
    logic [DATA_W:0]   sum;

    assign hi = p[2*DATA_W:DATA_W];

    // Partial-product add; hi never exceeds DATA_W bits, so the extra bit holds the carry.
    always_comb begin
        sum = hi;
        if (p[0]) begin
            sum = hi + {1'b0, a_reg};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= PC_IDLE;
            a_reg <= '0;
            p     <= '0;
            done  <= 1'b0;
        end else if (pc == PC_IDLE) begin
            done <= 1'b0;
            if (start) begin
                a_reg <= multiplicand;
                p     <= {1'b0, addend, multiplier};
                pc    <= PC_W'(1);
            end
        end else if (pc <= PC_LAST) begin
            // Logical right shift of the whole P with the add carry shifted in.
            p  <= {1'b0, sum, p[DATA_W-1:1]};
            pc <= pc + PC_W'(1);
        end else if (pc == PC_FINISH) begin
            done <= 1'b1;
            pc   <= pc + PC_W'(1);
        end else begin
            done <= 1'b0;
            pc   <= PC_IDLE;
        end
    end

    assign busy    = (pc != PC_IDLE);
    assign product = p[2*DATA_W-1:0];

endmodule
